// File: rtl/alu_seq_ctrl.sv
// Sequencing controller around the CPU ALU: valid/ready request in, single-cycle
// AND/OR/ADD/SUB or DATA_W-cycle shift-add MUL, result held until taken.
module alu_seq_ctrl #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [1:0]        ALUOp_i,
   input  logic [9:0]        funct_i,
   input  logic [DATA_W-1:0] src1_i,
   input  logic [DATA_W-1:0] src2_i,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic [DATA_W-1:0] result_o,
   output logic              zero_o,
   output logic              illegal_o,
   output logic              busy_o
);

   localparam int unsigned      CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
   typedef enum logic [2:0] {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_NOP} op_t;

   state_t            state;
   op_t               dec_op;
   op_t               op_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] acc_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] result_q;
   logic              zero_q;
   logic              illegal_q;
   logic              ready_q;
   logic              valid_q;
   logic              busy_q;
   logic [DATA_W-1:0] exec_res;
   logic [DATA_W-1:0] mul_sum;

   always_comb begin
      dec_op = OP_NOP;
      case (ALUOp_i)
         2'b01:        dec_op = OP_SUB;
         2'b10, 2'b11: dec_op = OP_ADD;
         default: begin
            case (funct_i)
               10'b0000000111: dec_op = OP_AND;
               10'b0000000110: dec_op = OP_OR;
               10'b0000000000: dec_op = OP_ADD;
               10'b0100000000: dec_op = OP_SUB;
               10'b0000001000: dec_op = OP_MUL;
               default:        dec_op = OP_NOP;
            endcase
         end
      endcase
   end

   always_comb begin
      exec_res = '0;
      case (op_q)
         OP_AND:  exec_res = a_q & b_q;
         OP_OR:   exec_res = a_q | b_q;
         OP_ADD:  exec_res = a_q + b_q;
         OP_SUB:  exec_res = a_q - b_q;
         default: exec_res = '0;
      endcase
   end

   // One shift-add step: the final step's sum is the product, captured straight into result_q.
   assign mul_sum = acc_q + (b_q[0] ? a_q : '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         op_q      <= OP_NOP;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  a_q     <= src1_i;
                  b_q     <= src2_i;
                  op_q    <= dec_op;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= (dec_op == OP_MUL) ? MUL : EXEC;
               end
            end
            EXEC: begin
               result_q  <= exec_res;
               zero_q    <= (exec_res == '0);
               illegal_q <= (op_q == OP_NOP);
               valid_q   <= 1'b1;
               state     <= DONE;
            end
            MUL: begin
               acc_q <= mul_sum;
               a_q   <= a_q << 1;
               b_q   <= b_q >> 1;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST) begin
                  result_q  <= mul_sum;
                  zero_q    <= (mul_sum == '0);
                  illegal_q <= 1'b0;
                  valid_q   <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (res_ready_i) begin
                  illegal_q <= 1'b0;
                  valid_q   <= 1'b0;
                  busy_q    <= 1'b0;
                  ready_q   <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready_o = ready_q;
   assign res_valid_o = valid_q;
   assign busy_o      = busy_q;
   assign result_o    = result_q;
   assign zero_o      = zero_q;
   assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: driver pushes model results, monitor pops and
// compares each presented result, its latency and its stability under backpressure.
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  alu_op = '0;
   logic [9:0]  funct = '0;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] result;
   logic        zero;
   logic        illegal;
   logic        busy;

   alu_seq_ctrl #(.DATA_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .ALUOp_i(alu_op), .funct_i(funct), .src1_i(src1), .src2_i(src2),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .result_o(result),
      .zero_o(zero), .illegal_o(illegal), .busy_o(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ill;
      int          first_n;
   } exp_t;

   exp_t sb[$];
   int   n = 0;
   int   total = 0;
   int   passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, required %h (negedge %0d)", name, act, req, n);
   endtask

   // Reference: plain arithmetic on the decode table; returns result, illegal flag, latency.
   task automatic model(input logic [1:0] op, input logic [9:0] fn, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output logic ill,
                        output int lat);
      logic [63:0] prod;
      ill = 1'b0;
      lat = 2;
      prod = {32'd0, a} * {32'd0, b};
      if (op == 2'b01) res = a - b;
      else if (op != 2'b00) res = a + b;
      else if (fn == 10'h007) res = a & b;
      else if (fn == 10'h006) res = a | b;
      else if (fn == 10'h000) res = a + b;
      else if (fn == 10'h100) res = a - b;
      else if (fn == 10'h008) begin
         res = prod[31:0];
         lat = 33;
      end else begin
         res = 32'd0;
         ill = 1'b1;
      end
   endtask

   // Monitor: samples 3 time units after each falling edge, before the next rising edge.
   logic        in_done = 1'b0;
   logic [31:0] cap_res;
   logic        cap_zero, cap_ill;
   always begin
      exp_t e;
      @(negedge clk);
      n++;
      #3;
      if (rst) begin
         in_done = 1'b0;
      end else begin
         chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~req_ready});
         if (!res_valid) begin
            chk("illegal_when_invalid", {31'd0, illegal}, 32'd0);
         end else begin
            chk("ready_low_in_done", {31'd0, req_ready}, 32'd0);
            if (!in_done) begin
               if (sb.size() == 0) begin
                  total++;
                  $display("FAIL unexpected_result: got result %h with nothing outstanding, required no result", result);
               end else begin
                  e = sb.pop_front();
                  chk("result", result, e.res);
                  chk("zero", {31'd0, zero}, {31'd0, e.zero});
                  chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
                  chk("latency_negedge", n, e.first_n);
               end
               cap_res  = result;
               cap_zero = zero;
               cap_ill  = illegal;
               in_done  = 1'b1;
            end else begin
               chk("hold_result", result, cap_res);
               chk("hold_zero", {31'd0, zero}, {31'd0, cap_zero});
               chk("hold_illegal", {31'd0, illegal}, {31'd0, cap_ill});
            end
            if (res_ready) in_done = 1'b0;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Issue one op, hold res_ready low for 'hold' valid cycles, return cycles spent busy.
   task automatic run_op(input logic [1:0] op, input logic [9:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input int hold, output int busy_cyc);
      exp_t e;
      int   lat;
      int   guard;
      busy_cyc = 0;
      guard = 0;
      while (!req_ready && guard < 200) begin step(); guard++; end
      if (!req_ready) begin
         chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
         return;
      end
      alu_op = op; funct = fn; src1 = a; src2 = b;
      req_valid = 1'b1;
      res_ready = (hold == 0);
      model(op, fn, a, b, e.res, e.ill, lat);
      e.zero = (e.res == 32'd0);
      e.first_n = n + lat;
      sb.push_back(e);
      step();
      req_valid = 1'b0;
      alu_op = 2'($urandom); funct = 10'($urandom); src1 = $urandom; src2 = $urandom;
      guard = 0;
      while (!res_valid && guard < 100) begin
         if (busy) busy_cyc++;
         step();
         guard++;
      end
      if (!res_valid) begin
         chk("res_valid_timeout", {31'd0, res_valid}, 32'd1);
         res_ready = 1'b0;
         return;
      end
      repeat (hold) begin busy_cyc++; step(); end
      res_ready = 1'b1;
      guard = 0;
      while (busy && guard < 100) begin busy_cyc++; step(); guard++; end
      res_ready = 1'b0;
   endtask

   logic [9:0] legal_f [5] = '{10'h007, 10'h006, 10'h000, 10'h100, 10'h008};

   initial begin
      int         bc;
      logic [1:0] op;
      logic [9:0] fn;
      logic [31:0] a, b;
      repeat (3) step();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero_illegal", {30'd0, zero, illegal}, 32'd0);
      rst = 1'b0;
      step();

      run_op(2'b00, 10'h000, 32'd5, 32'd7, 0, bc);
      chk("t1_busy_cycles", bc, 32'd2);
      run_op(2'b01, 10'($urandom), 32'd9, 32'd9, 0, bc);
      run_op(2'b01, 10'($urandom), 32'd0, 32'd1, 0, bc);
      run_op(2'b00, 10'h008, 32'hFFFF_FFFF, 32'd3, 0, bc);
      chk("t3_busy_cycles", bc, 32'd33);
      run_op(2'b00, 10'h008, 32'h0001_0000, 32'h0001_0000, 0, bc);
      run_op(2'b00, 10'h007, 32'h0000_F0F0, 32'h0000_FF00, 5, bc);
      chk("t4_busy_cycles", bc, 32'd7);
      run_op(2'b00, 10'h001, $urandom, $urandom, 0, bc);
      run_op(2'b00, 10'h006, 32'd1, 32'd2, 0, bc);

      // Reset at MUL iteration 10: no result may ever appear for it.
      alu_op = 2'b00; funct = 10'h008; src1 = 32'h1234_5678; src2 = 32'h0000_0FFF;
      req_valid = 1'b1;
      res_ready = 1'b1;
      step();
      req_valid = 1'b0;
      repeat (10) step();
      chk("t6_busy_mid_mul", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_busy_after_rst", {31'd0, busy}, 32'd0);
      chk("t6_valid_after_rst", {31'd0, res_valid}, 32'd0);
      chk("t6_ready_after_rst", {31'd0, req_ready}, 32'd1);
      repeat (40) step();
      res_ready = 1'b0;
      run_op(2'b00, 10'h000, 32'd1, 32'd1, 0, bc);
      chk("t6_add_busy_cycles", bc, 32'd2);

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         fn = ($urandom_range(0, 3) != 0) ? legal_f[$urandom_range(0, 4)] : 10'($urandom);
         a = $urandom;
         b = ($urandom_range(0, 4) == 0) ? a : $urandom;
         run_op(op, fn, a, b, int'($urandom_range(0, 3)), bc);
      end

      repeat (5) step();
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time exceeded, required completion");
      $fatal(1, "timeout");
   end

endmodule
